// File: rtl/uart_rx_oversampled.sv
// UART receiver sampling the line at OVERSAMPLE ticks per bit, LSB first,
// with start-bit glitch rejection, stop-bit checking and a break-hold state.
module uart_rx_oversampled #(
    parameter int WIDTH_WORD    = 8,
    parameter int CANT_BIT_STOP = 2,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_rx,
    output logic [WIDTH_WORD-1:0] o_data,
    output logic                  o_rx_done,
    output logic                  o_frame_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(WIDTH_WORD + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH_WORD - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(CANT_BIT_STOP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic rx_meta;
    logic rx_s;

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [WIDTH_WORD-1:0] shift_q, shift_d;
    logic                  err_q, err_d;
    logic [WIDTH_WORD-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;

    // Idle-high synchroniser so reset never looks like a start bit.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        err_d   = err_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                err_d  = 1'b0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (i_tick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[WIDTH_WORD-1:1]};
                        if (bit_q == LAST_DATA) begin
                            bit_d   = '0;
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            err_d = 1'b1;
                        end
                        // The final sample is folded in directly since err_q lags by a cycle.
                        if (bit_q == LAST_STOP) begin
                            bit_d = '0;
                            err_d = 1'b0;
                            if (err_q || !rx_s) begin
                                ferr_d  = 1'b1;
                                state_d = S_BREAK;
                            end else begin
                                data_d  = shift_q;
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_data        = data_q;
    assign o_rx_done     = done_q;
    assign o_frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: directed frames plus random
// traffic, checked against a queue of expected words and expected errors.
module tb_uart_rx_oversampled;

    localparam int W         = 8;
    localparam int NSTOP     = 2;
    localparam int OS        = 16;
    localparam int TICK_CLKS = 4;
    localparam int BIT_CLKS  = OS * TICK_CLKS;
    localparam int WIN_LO    = 664;
    localparam int WIN_HI    = 692;

    logic         i_clock = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_tick  = 1'b0;
    logic         i_rx    = 1'b1;
    logic [W-1:0] o_data;
    logic         o_rx_done;
    logic         o_frame_error;

    int tests = 0;
    int fails = 0;

    // Reference model: words owed to the host in order, and frame errors owed.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_data = '0;
    int           exp_err = 0;

    int cyc = 0;
    int frame_start = 0;
    int n_done = 0;
    int n_err = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;

    uart_rx_oversampled #(
        .WIDTH_WORD   (W),
        .CANT_BIT_STOP(NSTOP),
        .OVERSAMPLE   (OS)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_tick       (i_tick),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_rx_done    (o_rx_done),
        .o_frame_error(o_frame_error)
    );

    always #5 i_clock = ~i_clock;

    always @(posedge i_clock) cyc++;

    initial begin
        @(negedge i_clock);
        forever begin
            repeat (TICK_CLKS - 1) @(negedge i_clock);
            i_tick = 1'b1;
            @(negedge i_clock);
            i_tick = 1'b0;
        end
    end

    // Cycle-by-cycle monitor, sampled 1 time unit after the active edge.
    always begin
        @(posedge i_clock);
        #1;
        tests++;
        assert ((o_rx_done & o_frame_error) === 1'b0) else begin
            fails++;
            $error("FAIL both_strobes: done=%b ferr=%b, required not both", o_rx_done, o_frame_error);
        end
        if (o_rx_done === 1'b1) begin
            n_done++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            tests++;
            assert ((exp_q.size() != 0) === 1'b1) else begin
                fails++;
                $error("FAIL unexpected_done: data=%h, required no strobe", o_data);
            end
            if (exp_q.size() != 0) model_data = exp_q.pop_front();
            tests++;
            assert (((cyc - frame_start) >= WIN_LO && (cyc - frame_start) <= WIN_HI) === 1'b1) else begin
                fails++;
                $error("FAIL done_timing: %0d clocks after start, required %0d..%0d", cyc - frame_start, WIN_LO, WIN_HI);
            end
        end
        if (o_frame_error === 1'b1) begin
            n_err++;
            tests++;
            assert ((exp_err > 0) === 1'b1) else begin
                fails++;
                $error("FAIL unexpected_ferr: got frame error, required none");
            end
            if (exp_err > 0) exp_err--;
            tests++;
            assert (((cyc - frame_start) >= WIN_LO && (cyc - frame_start) <= WIN_HI) === 1'b1) else begin
                fails++;
                $error("FAIL ferr_timing: %0d clocks after start, required %0d..%0d", cyc - frame_start, WIN_LO, WIN_HI);
            end
        end
        tests++;
        assert (o_data === model_data) else begin
            fails++;
            $error("FAIL data_hold: o_data=%h, required %h", o_data, model_data);
        end
    end

    task automatic send_bit(input logic b);
        i_rx = b;
        repeat (BIT_CLKS) @(negedge i_clock);
    endtask

    task automatic idle_bits(input int n);
        i_rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge i_clock);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic s1, input logic s2);
        frame_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < W; i++) send_bit(d[i]);
        send_bit(s1);
        send_bit(s2);
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0d, required %0d", tag, got, want);
        end
    endtask

    task automatic check_data(input string tag, input logic [W-1:0] want);
        tests++;
        assert (o_data === want) else begin
            fails++;
            $error("FAIL %s: o_data=%h, required %h", tag, o_data, want);
        end
    endtask

    initial begin
        int d0;
        int e0;
        logic [W-1:0] rw;
        logic bad;
        logic s1;
        int gap;

        // Reset state
        repeat (5) @(negedge i_clock);
        i_reset = 1'b0;
        check_data("reset_data", 8'h00);
        check_int("reset_done", int'(o_rx_done), 0);
        check_int("reset_ferr", int'(o_frame_error), 0);
        idle_bits(2);

        // Frame 0x00
        d0 = n_done; e0 = n_err;
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, 1'b1);
        idle_bits(1);
        check_int("f00_done_count", n_done - d0, 1);
        check_int("f00_ferr_count", n_err - e0, 0);
        check_data("f00_data", 8'h00);

        // 0x08 then 0xA5 with one idle bit between
        d0 = n_done;
        exp_q.push_back(8'h08);
        send_frame(8'h08, 1'b1, 1'b1);
        idle_bits(1);
        check_data("f08_data", 8'h08);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1);
        idle_bits(1);
        check_int("pair_done_count", n_done - d0, 2);
        check_data("fA5_data", 8'hA5);

        // Start-bit glitch of 4 ticks
        d0 = n_done; e0 = n_err;
        i_rx = 1'b0;
        repeat (4 * TICK_CLKS) @(negedge i_clock);
        idle_bits(2);
        check_int("glitch_done_count", n_done - d0, 0);
        check_int("glitch_ferr_count", n_err - e0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_bits(1);
        check_int("f3C_done_count", n_done - d0, 1);
        check_data("f3C_data", 8'h3C);

        // Low second stop bit, then line held low for 40 bits
        d0 = n_done; e0 = n_err;
        exp_err++;
        send_frame(8'h7E, 1'b1, 1'b0);
        i_rx = 1'b0;
        repeat (40 * BIT_CLKS) @(negedge i_clock);
        check_int("break_ferr_count", n_err - e0, 1);
        check_int("break_done_count", n_done - d0, 0);
        check_data("break_data_kept", 8'h3C);
        idle_bits(2);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b1);
        idle_bits(1);
        check_int("f11_done_count", n_done - d0, 1);
        check_int("f11_ferr_count", n_err - e0, 1);
        check_data("f11_data", 8'h11);

        // Reset after 3 data bits of 0x55
        d0 = n_done; e0 = n_err;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        i_reset = 1'b1;
        i_rx = 1'b1;
        model_data = '0;
        @(negedge i_clock);
        i_reset = 1'b0;
        check_data("midreset_data", 8'h00);
        check_int("midreset_done", int'(o_rx_done), 0);
        check_int("midreset_ferr", int'(o_frame_error), 0);
        idle_bits(12);
        check_int("midreset_done_count", n_done - d0, 0);
        check_int("midreset_ferr_count", n_err - e0, 0);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle_bits(1);
        check_data("fFF_data", 8'hFF);

        // Back-to-back frames with zero idle gap
        d0 = n_done;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        idle_bits(1);
        check_int("b2b_done_count", n_done - d0, 2);
        check_int("b2b_spacing", last_done_cyc - prev_done_cyc, 11 * BIT_CLKS);
        check_data("b2b_data", 8'h34);

        // Random traffic, with occasional bad stop bits
        for (int k = 0; k < 16; k++) begin
            rw  = W'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            s1  = $urandom_range(0, 1) == 1;
            gap = $urandom_range(0, 2);
            if (bad) begin
                exp_err++;
                send_frame(rw, s1, ~s1);
                idle_bits(gap + 1);
            end else begin
                exp_q.push_back(rw);
                send_frame(rw, 1'b1, 1'b1);
                if (gap > 0) idle_bits(gap);
            end
        end
        idle_bits(2);
        check_int("final_words_pending", exp_q.size(), 0);
        check_int("final_errs_pending", exp_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
